// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding, ACK/NACK bus levels and
// the default board device address (also used by the i2c_master top).
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_tgt_state_t;

  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;
  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h3B;

endpackage

// File: rtl/i2c_in_filter.sv
// I2C pin conditioner: 2-flop synchronizer followed by a stable-value filter.
// The output only follows the synchronized input after it has differed from
// the current output for FILT consecutive cycles (pin-to-output 2+FILT cycles).
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset (output resets high,
//                  the idle level of an open-drain bus)
//   i_pin        : raw pin level
//   o_filt       : synchronized, deglitched level
module i2c_in_filter #(
  parameter int unsigned FILT = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_filt
);

  localparam int unsigned CW = $clog2(FILT + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          filt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], i_pin};
      if (sync_q[1] != filt_q) begin
        if (cnt_q == CW'(FILT - 1)) begin
          filt_q <= sync_q[1];
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign o_filt = filt_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target responder with an internal register file.
// Write: [addr+W] [reg pointer] [data...]; each data byte commits to reg[ptr]
// and post-increments ptr. Read: pointer write, repeated START, [addr+R],
// then bytes from reg[ptr] with post-increment until the master NACKs.
// No clock stretching; SDA is open-drain (o_sda=0 pulls low, 1 releases).
// Ports:
//   i_clk, i_rst          : clock (>= 20x SCL), synchronous active-high reset
//   i_scl, i_sda          : bus pin levels
//   o_sda                 : SDA drive (0 = pull low, 1 = release)
//   o_wr_stb/addr/data    : one-cycle notification of a committed write
//   i_lrd_addr/o_lrd_data : combinational local read port
//   o_busy                : addressed transaction in progress
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = I2C_DEFAULT_ADDR,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned FILT     = 3,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_scl,
  input  logic          i_sda,
  output logic          o_sda,
  output logic          o_wr_stb,
  output logic [AW-1:0] o_wr_addr,
  output logic [7:0]    o_wr_data,
  input  logic [AW-1:0] i_lrd_addr,
  output logic [7:0]    o_lrd_data,
  output logic          o_busy
);

  logic scl_f, sda_f;

  i2c_in_filter #(.FILT(FILT)) u_scl_filt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_pin (i_scl),
    .o_filt(scl_f)
  );

  i2c_in_filter #(.FILT(FILT)) u_sda_filt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_pin (i_sda),
    .o_filt(sda_f)
  );

  i2c_tgt_state_t state_q;
  logic           scl_prev_q, sda_prev_q;
  logic [2:0]     bitcnt_q;
  logic [7:0]     shift_q;
  logic           rw_q;
  logic           ack_q;  // ACK states: ACK bit is on the bus; RDATA_ACK: master ACKed
  logic [AW-1:0]  ptr_q;
  logic           sda_q;
  logic           busy_q;
  logic           wr_stb_q;
  logic [AW-1:0]  wr_addr_q;
  logic [7:0]     wr_data_q;
  logic [7:0]     regs_q [DEPTH];

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  assign scl_rise  = scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f & scl_prev_q;
  // SCL must be high on both sides of the SDA edge, so an SDA change that
  // lands in the same cycle as an SCL edge is never taken as START/STOP.
  assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
  assign rx_byte   = {shift_q[6:0], sda_f};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      ptr_q      <= '0;
      sda_q      <= 1'b1;
      busy_q     <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      regs_q     <= '{default: '0};
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
      wr_stb_q   <= 1'b0;
      // Commit one cycle after the strobe so the local port shows the old
      // value during the strobe cycle.
      if (wr_stb_q) regs_q[wr_addr_q] <= wr_data_q;

      if (start_det) begin
        state_q  <= ADDR;
        bitcnt_q <= '0;
        ack_q    <= 1'b0;
        sda_q    <= 1'b1;
      end else if (stop_det) begin
        state_q <= IDLE;
        sda_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ADDR, REG, WDATA: begin
            if (scl_rise) begin
              shift_q  <= rx_byte;
              bitcnt_q <= bitcnt_q + 1'b1;
              ack_q    <= 1'b0;
              if (bitcnt_q == 3'd7) begin
                if (state_q == ADDR) begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state_q <= ADDR_ACK;
                    busy_q  <= 1'b1;
                    rw_q    <= rx_byte[0];
                  end else begin
                    state_q <= IGNORE;
                    busy_q  <= 1'b0;
                  end
                end else if (state_q == REG) begin
                  ptr_q   <= rx_byte[AW-1:0];
                  state_q <= REG_ACK;
                end else begin
                  wr_stb_q  <= 1'b1;
                  wr_addr_q <= ptr_q;
                  wr_data_q <= rx_byte;
                  ptr_q     <= ptr_q + 1'b1;
                  state_q   <= WDATA_ACK;
                end
              end
            end
          end

          ADDR_ACK, REG_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_q) begin
                sda_q <= I2C_ACK;
                ack_q <= 1'b1;
              end else begin
                ack_q    <= 1'b0;
                bitcnt_q <= '0;
                if (state_q == ADDR_ACK && rw_q) begin
                  // Bit 7 goes straight to the pin; the rest queue up MSB-first.
                  sda_q   <= regs_q[ptr_q][7];
                  shift_q <= {regs_q[ptr_q][6:0], 1'b0};
                  state_q <= RDATA;
                end else begin
                  sda_q   <= 1'b1;
                  state_q <= (state_q == ADDR_ACK) ? REG : WDATA;
                end
              end
            end
          end

          RDATA: begin
            if (scl_fall) begin
              if (bitcnt_q == 3'd7) begin
                sda_q   <= 1'b1;
                ptr_q   <= ptr_q + 1'b1;
                ack_q   <= 1'b0;
                state_q <= RDATA_ACK;
              end else begin
                bitcnt_q <= bitcnt_q + 1'b1;
                sda_q    <= shift_q[7];
                shift_q  <= {shift_q[6:0], 1'b0};
              end
            end
          end

          RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_f == I2C_NACK) state_q <= IGNORE;
              else                   ack_q   <= 1'b1;
            end else if (scl_fall && ack_q) begin
              sda_q    <= regs_q[ptr_q][7];
              shift_q  <= {regs_q[ptr_q][6:0], 1'b0};
              bitcnt_q <= '0;
              ack_q    <= 1'b0;
              state_q  <= RDATA;
            end
          end

          default: ;  // IDLE, IGNORE: wait for START/STOP
        endcase
      end
    end
  end

  assign o_sda      = sda_q;
  assign o_busy     = busy_q;
  assign o_wr_stb   = wr_stb_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_lrd_data = regs_q[i_lrd_addr];

endmodule

// File: tb/tb_i2c_target.sv
// Scoreboard bench for i2c_target: a bit-level I2C master model drives the
// bus, expected write strobes and bus responses (ACK bits, read bytes) are
// queued by the stimulus, and a monitor process pops and compares them.
module tb_i2c_target;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m_scl = 1'b1;
  logic          m_sda = 1'b1;
  logic [AW-1:0] lrd_addr = '0;
  logic          sda_line;
  logic          o_sda, o_wr_stb, o_busy;
  logic [AW-1:0] o_wr_addr;
  logic [7:0]    o_wr_data, o_lrd_data;

  assign sda_line = m_sda & o_sda;

  always #5 clk = ~clk;

  i2c_target #(.DEV_ADDR(7'h3B), .DEPTH(16), .FILT(3)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_scl     (m_scl),
    .i_sda     (sda_line),
    .o_sda     (o_sda),
    .o_wr_stb  (o_wr_stb),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data),
    .i_lrd_addr(lrd_addr),
    .o_lrd_data(o_lrd_data),
    .o_busy    (o_busy)
  );

  typedef struct { string name; logic [7:0] val; } rx_t;
  typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;

  rx_t        exp_rx[$];
  logic [7:0] obs_rx[$];
  wr_t        exp_wr[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         low_cnt = 0;
  logic       prev_stb = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  always @(posedge clk) if (o_sda == 1'b0) low_cnt <= low_cnt + 1;

  // Monitor: compares every DUT write strobe and every observed bus response
  initial begin
    wr_t w;
    rx_t e;
    logic [7:0] o;
    forever begin
      @(negedge clk);
      if (o_wr_stb) begin
        chk("wr_stb_width", {31'b0, prev_stb}, 0);
        chk("wr_expected", {31'b0, exp_wr.size() > 0}, 1);
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          chk("wr_addr", {28'b0, o_wr_addr}, {28'b0, w.a});
          chk("wr_data", {24'b0, o_wr_data}, {24'b0, w.d});
        end
      end
      prev_stb = o_wr_stb;
      while (obs_rx.size() > 0) begin
        o = obs_rx.pop_front();
        chk("rx_expected", {31'b0, exp_rx.size() > 0}, 1);
        if (exp_rx.size() > 0) begin
          e = exp_rx.pop_front();
          chk(e.name, {24'b0, o}, {24'b0, e.val});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each bit starts with SCL just pulled low; SDA moves 8 clocks later.
  task automatic send_bit(input logic b, input logic glitch);
    wait_clk(8);  m_sda = b;
    wait_clk(12); m_scl = 1'b1;
    if (glitch) begin
      wait_clk(10); m_sda = ~b;
      wait_clk(1);  m_sda = b;
      wait_clk(9);
    end else begin
      wait_clk(20);
    end
    m_scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wait_clk(8);  m_sda = 1'b1;
    wait_clk(12); m_scl = 1'b1;
    wait_clk(10); b = sda_line;
    wait_clk(10); m_scl = 1'b0;
  endtask

  task automatic start_c();
    m_sda = 1'b1; wait_clk(20);
    m_scl = 1'b1; wait_clk(20);
    m_sda = 1'b0; wait_clk(20);
    m_scl = 1'b0;
  endtask

  task automatic stop_c();
    wait_clk(8);  m_sda = 1'b0;
    wait_clk(12); m_scl = 1'b1;
    wait_clk(20); m_sda = 1'b1;
    wait_clk(20);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string name,
                            input logic [7:0] gmask = 8'h00);
    logic a;
    exp_rx.push_back('{name: name, val: {7'b0, exp_ack}});
    for (int i = 7; i >= 0; i--) send_bit(b[i], gmask[i]);
    recv_bit(a);
    obs_rx.push_back({7'b0, a});
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic mack, input string name);
    logic [7:0] d;
    logic       b;
    exp_rx.push_back('{name: name, val: exp});
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    obs_rx.push_back(d);
    send_bit(mack, 1'b0);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d);
    exp_wr.push_back('{a: a, d: d});
  endtask

  task automatic lrd_chk(input logic [AW-1:0] a, input logic [7:0] exp, input string name);
    lrd_addr = a;
    @(negedge clk);
    chk(name, {24'b0, o_lrd_data}, {24'b0, exp});
  endtask

  initial begin
    int low0;

    // Reset state
    wait_clk(4);
    chk("rst_sda", {31'b0, o_sda}, 1);
    chk("rst_busy", {31'b0, o_busy}, 0);
    chk("rst_wr_stb", {31'b0, o_wr_stb}, 0);
    chk("rst_wr_addr", {28'b0, o_wr_addr}, 0);
    chk("rst_wr_data", {24'b0, o_wr_data}, 0);
    lrd_chk(4'd0, 8'h00, "rst_lrd0");
    rst = 1'b0;
    wait_clk(10);

    // Single write: reg 5 <= A5
    push_wr(4'd5, 8'hA5);
    start_c();
    write_byte(8'h76, 1'b0, "t1_addr_ack");
    chk("t1_busy", {31'b0, o_busy}, 1);
    write_byte(8'h05, 1'b0, "t1_reg_ack");
    write_byte(8'hA5, 1'b0, "t1_data_ack");
    stop_c();
    wait_clk(10);
    chk("t1_busy_after_stop", {31'b0, o_busy}, 0);
    lrd_chk(4'd5, 8'hA5, "t1_lrd5");

    // Burst write with pointer wrap 14, 15, 0
    push_wr(4'd14, 8'h11);
    push_wr(4'd15, 8'h22);
    push_wr(4'd0,  8'h33);
    start_c();
    write_byte(8'h76, 1'b0, "t2_addr_ack");
    write_byte(8'h0E, 1'b0, "t2_reg_ack");
    write_byte(8'h11, 1'b0, "t2_d0_ack");
    write_byte(8'h22, 1'b0, "t2_d1_ack");
    write_byte(8'h33, 1'b0, "t2_d2_ack");
    stop_c();
    wait_clk(10);
    lrd_chk(4'd14, 8'h11, "t2_lrd14");
    lrd_chk(4'd15, 8'h22, "t2_lrd15");
    lrd_chk(4'd0,  8'h33, "t2_lrd0");

    // Preload regs 3,4 then read them back through a repeated START
    push_wr(4'd3, 8'hC3);
    push_wr(4'd4, 8'h4D);
    start_c();
    write_byte(8'h76, 1'b0, "t3_wr_addr_ack");
    write_byte(8'h03, 1'b0, "t3_wr_reg_ack");
    write_byte(8'hC3, 1'b0, "t3_wr_d0_ack");
    write_byte(8'h4D, 1'b0, "t3_wr_d1_ack");
    stop_c();
    start_c();
    write_byte(8'h76, 1'b0, "t3_addr_w_ack");
    write_byte(8'h03, 1'b0, "t3_ptr_ack");
    start_c();
    write_byte(8'h77, 1'b0, "t3_addr_r_ack");
    read_byte(8'hC3, 1'b0, "t3_rd_reg3");
    read_byte(8'h4D, 1'b1, "t3_rd_reg4");
    wait_clk(10);
    chk("t3_sda_released", {31'b0, o_sda}, 1);
    chk("t3_busy_before_stop", {31'b0, o_busy}, 1);
    stop_c();
    wait_clk(10);
    chk("t3_busy_after_stop", {31'b0, o_busy}, 0);

    // Address mismatch: never ACKed, no write, not busy
    low0 = low_cnt;
    start_c();
    write_byte(8'h78, 1'b1, "t4_addr_nack");
    write_byte(8'h01, 1'b1, "t4_reg_nack");
    chk("t4_busy", {31'b0, o_busy}, 0);
    write_byte(8'h99, 1'b1, "t4_data_nack");
    stop_c();
    chk("t4_sda_low_cycles", low_cnt - low0, 0);
    push_wr(4'd9, 8'h66);
    start_c();
    write_byte(8'h76, 1'b0, "t4_next_addr_ack");
    write_byte(8'h09, 1'b0, "t4_next_reg_ack");
    write_byte(8'h66, 1'b0, "t4_next_data_ack");
    stop_c();
    wait_clk(10);
    lrd_chk(4'd9, 8'h66, "t4_lrd9");

    // 1-cycle SDA glitches while SCL high (fake STOP on bit 6, fake START on bit 5)
    push_wr(4'd10, 8'h3C);
    start_c();
    write_byte(8'h76, 1'b0, "t5_addr_ack");
    write_byte(8'h0A, 1'b0, "t5_reg_ack");
    write_byte(8'h3C, 1'b0, "t5_data_ack", 8'h60);
    chk("t5_busy", {31'b0, o_busy}, 1);
    stop_c();
    wait_clk(10);
    lrd_chk(4'd10, 8'h3C, "t5_lrd10");

    // Reset while the target holds the address ACK low
    start_c();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h76 >> i), 1'b0);
    m_sda = 1'b1;
    for (int k = 0; k < 40 && o_sda; k++) @(negedge clk);
    chk("t6_ack_driven", {31'b0, o_sda}, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_sda_after_rst", {31'b0, o_sda}, 1);
    chk("t6_busy_after_rst", {31'b0, o_busy}, 0);
    @(negedge clk); rst = 1'b0;
    lrd_chk(4'd5, 8'h00, "t6_regs_cleared");
    wait_clk(20); m_scl = 1'b1;
    wait_clk(20); m_scl = 1'b0;
    stop_c();
    push_wr(4'd7, 8'h5A);
    start_c();
    write_byte(8'h76, 1'b0, "t6_addr_ack");
    write_byte(8'h07, 1'b0, "t6_reg_ack");
    write_byte(8'h5A, 1'b0, "t6_data_ack");
    stop_c();
    wait_clk(10);
    lrd_chk(4'd7, 8'h5A, "t6_lrd7");

    wait_clk(20);
    chk("exp_wr_drained", exp_wr.size(), 0);
    chk("exp_rx_drained", exp_rx.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) responder for the board-level I2C bus, the opposite end of the existing `i2c_master`. It decodes START/STOP, matches a 7-bit device address and exposes an internal register file. The master writes the file with an 8-bit register pointer plus data bytes and reads it back through a repeated START. It connects to a PMOD pin pair through the same open-drain wrapper the top level uses (drive 0 or release to Z); it never drives SCL (no clock stretching).

## Interface
- `DEV_ADDR`, 7'h3B: 7-bit device address this target responds to.
- `DEPTH`, 16: register file depth, a power of two between 2 and 256; pointer width `AW = $clog2(DEPTH)`.
- `FILT`, 3: SCL/SDA glitch filter length in `i_clk` cycles.
- `i_clk` in 1: system clock; one clock, all logic on the rising edge. Must be ≥ 20× the SCL rate.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_scl` in 1: SCL pin level.
- `i_sda` in 1: SDA pin level.
- `o_sda` out 1: 0 pulls SDA low; 1 releases it (wrapper maps 1 to Z).
- `o_wr_stb` out 1: one-cycle pulse when a written byte commits to the register file.
- `o_wr_addr` out AW: register index of the committed write.
- `o_wr_data` out 8: committed write data.
- `i_lrd_addr` in AW: local read port index.
- `o_lrd_data` out 8: `reg[i_lrd_addr]`, combinational.
- `o_busy` out 1: high from an address-matched START until STOP or a mismatch.

## Operation
- Input path: each of SCL and SDA passes through a 2-flop synchronizer, then a FILT-cycle stable-value filter. Edge detectors on the filtered SCL produce `scl_rise` and `scl_fall`.
- START condition: filtered SDA falls while SCL is high. STOP condition: filtered SDA rises while SCL is high. Both take priority over bit handling in the same cycle.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- START from any state → ADDR: bit counter cleared, `o_sda`=1. This covers repeated START.
- STOP from any state → IDLE: `o_sda`=1, `o_busy`=0.
- Bits are sampled on `scl_rise`, MSB first. Counter 0..7; the 8th bit completes the byte.
- ADDR:
  - If `addr[7:1]==DEV_ADDR`: → ADDR_ACK; `o_busy`=1; latch R/W.
  - Otherwise → IGNORE. IGNORE leaves only on START or STOP; `o_sda` stays 1.
- ACK drive and release:
  - At the `scl_fall` that ends the 8th bit, `o_sda`←0.
  - At the next `scl_fall`, release.
  - The ACK state then advances: ADDR_ACK goes → REG if W, → RDATA if R (see RDATA for read bit timing).
- REG: the received byte's low AW bits load the pointer → REG_ACK → WDATA. Upper pointer bits are ignored.
- WDATA:
  - Byte complete → write `reg[ptr]`.
  - Pulse `o_wr_stb` with the pre-increment ptr and the data.
  - `ptr`←`ptr+1` mod DEPTH (wraps DEPTH-1→0).
  - → WDATA_ACK → WDATA.
  - Every data byte is ACKed.
- RDATA:
  - Load shift register from `reg[ptr]` at entry.
  - Drive bit 7 on the `scl_fall` that ends the ACK phase; each following bit goes out on `scl_fall`.
  - After 8 bits, release SDA; `ptr`←`ptr+1` mod DEPTH; → RDATA_ACK.
- RDATA_ACK: sample SDA on `scl_rise`.
  - 0 (master ACK) → RDATA with the next byte.
  - 1 (NACK) → IGNORE until STOP/START.
- Reset values: `o_sda`=1, `o_wr_stb`=0, `o_wr_addr`=0, `o_wr_data`=0, `o_busy`=0, FSM=IDLE, ptr=0, all registers 0.
- Reset mid-transaction releases SDA on the next clock edge and discards any partial byte.

## Timing
- Pin to filtered-signal latency: 2 + FILT cycles.
- All SDA changes occur in the cycle after the `scl_fall` detection, giving hold ≥ 2+FILT clock periods after the true SCL fall.
- `o_wr_stb` asserts in the cycle after the 8th `scl_rise` detection. It lasts exactly 1 cycle.
- `o_lrd_data` has zero latency. A local read of the address being written in the `o_wr_stb` cycle returns the old value; the new value appears the next cycle.
- START/STOP during an ACK or read bit: SDA released in the same cycle the condition is detected.

## Structure
- Shared package `i2c_pkg`: FSM state enum `i2c_tgt_state_t`, `I2C_ACK`=1'b0, `I2C_NACK`=1'b1, and the default device address constant shared with the master top.
- Sub-module `i2c_in_filter`: 2-flop synchronizer plus FILT-cycle filter. It is instantiated twice (SCL and SDA) and is reusable by the master.
- Register file, FSM and shift register stay inline.

## Test plan
- Write to 0x3B with register 0x05 and data 0xA5 → ACK on all 3 bytes; one `o_wr_stb` with addr 5, data 0xA5; `o_lrd_data`=0xA5 at index 5.
- Burst write with DEPTH=16: register 0x0E, data 0x11,0x22,0x33 → writes land at 14, 15, 0 (wrap); three strobes.
- Write pointer 0x03, repeated START, read 0x3B, master ACK then NACK → target returns reg[3] then reg[4]; SDA released after the NACK; `o_busy` falls at STOP.
- Address 0x3C (mismatch) with write data → SDA never driven low, no strobe, `o_busy`=0; the next START to 0x3B is ACKed.
- 1-cycle SDA glitch while SCL is high (FILT=3) → no START/STOP detected, state unchanged.
- `i_rst` asserted while the target drives ACK low → `o_sda`=1 next cycle, FSM=IDLE; a following full transaction completes normally.
